// File: rtl/cp_remover.sv
// Cyclic-prefix remover: drops CP_SIZE samples ahead of every FFT_SIZE-sample OFDM symbol,
// emits symbols with tlast per symbol and reports completed-symbol count and truncated frames.
module cp_remover #(
  parameter int FFT_SIZE = 1024,
  parameter int CP_SIZE  = 128,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [15:0]       sym_count,
  output logic              trunc_err
);

  localparam int CNT_MAX = (FFT_SIZE > CP_SIZE) ? FFT_SIZE : CP_SIZE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CP_LAST  = CNT_W'(CP_SIZE - 1);
  localparam logic [CNT_W-1:0] FFT_LAST = CNT_W'(FFT_SIZE - 1);

  typedef enum logic {S_CP, S_DATA} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             frame_start;  // next accepted beat is the first of a new frame
  logic             accept;
  logic             sym_end;

  // CP samples are discarded, so only the data phase is throttled by the output register.
  assign i_tready = (state == S_CP) | ~o_tvalid | o_tready;
  assign accept   = i_tvalid & i_tready;
  assign sym_end  = (cnt == FFT_LAST);

  // NOTE: all state below is updated with non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_CP;
      cnt         <= '0;
      sym_count   <= '0;
      frame_start <= 1'b1;
      o_tdata     <= '0;
      o_tlast     <= 1'b0;
      o_tvalid    <= 1'b0;
      trunc_err   <= 1'b0;
    end else if (clear) begin
      state       <= S_CP;
      cnt         <= '0;
      sym_count   <= '0;
      frame_start <= 1'b1;
      o_tdata     <= '0;
      o_tlast     <= 1'b0;
      o_tvalid    <= 1'b0;
      trunc_err   <= 1'b0;
    end else begin
      trunc_err <= 1'b0;
      if (o_tvalid && o_tready) o_tvalid <= 1'b0;

      if (accept) begin
        frame_start <= i_tlast;
        unique case (state)
          S_CP: begin
            // Previous frame's count stays readable until the new frame actually starts.
            if (frame_start) sym_count <= '0;
            if (i_tlast) begin
              cnt   <= '0;
              state <= S_CP;
              if (frame_start) trunc_err <= 1'b1;
            end else if (cnt == CP_LAST) begin
              cnt   <= '0;
              state <= S_DATA;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DATA: begin
            o_tdata  <= i_tdata;
            o_tvalid <= 1'b1;
            o_tlast  <= sym_end | i_tlast;
            if (sym_end) begin
              cnt   <= '0;
              state <= S_CP;
              if (sym_count != 16'hFFFF) sym_count <= sym_count + 16'd1;
            end else if (i_tlast) begin
              cnt       <= '0;
              state     <= S_CP;
              trunc_err <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= S_CP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp_remover.sv
// Directed bench for cp_remover with FFT_SIZE=8, CP_SIZE=2: checks stripped output sequences,
// symbol count, truncation pulses, clear and asynchronous reset behaviour.
module tb_cp_remover;

  localparam int FFT = 8;
  localparam int CP  = 2;
  localparam int SYM = FFT + CP;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic [31:0] i_tdata, o_tdata;
  logic        i_tlast, i_tvalid, i_tready;
  logic        o_tlast, o_tvalid, o_tready;
  logic [15:0] sym_count;
  logic        trunc_err;

  int checks = 0;
  int errors = 0;
  int trunc_seen;
  logic [32:0] got[$];
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  cp_remover #(.FFT_SIZE(FFT), .CP_SIZE(CP), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .sym_count(sym_count), .trunc_err(trunc_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, observe what the next rising edge will capture.
  task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic rdy,
                       output logic acc);
    @(negedge clk);
    i_tvalid = v; i_tdata = d; i_tlast = l; o_tready = rdy;
    #1;
    acc = v && i_tready;
    if (o_tvalid && o_tready) got.push_back({o_tlast, o_tdata});
    if (trunc_err) trunc_seen++;
  endtask

  task automatic run_frame(input int n, input int base, input bit rnd);
    int idx;
    int guard;
    logic acc;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 1000) begin
      cycle(1'b1, 32'(base + idx), idx == n - 1, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      if ((idx % SYM) < CP) check("cp_ready", i_tready, 1);
      if (acc) idx++;
      guard++;
    end
    if (idx < n) check("input_timeout", idx, n);
    for (int k = 0; k < 4; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, acc);
  endtask

  // Reference: positions CP..SYM-1 of each symbol are kept; tlast at symbol end or frame end.
  task automatic compare_out(input int n, input int base);
    int m;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if ((i % SYM) >= CP)
        exp_q.push_back({((i % SYM) == SYM - 1) || (i == n - 1), 32'(base + i)});
    end
    check("out_len", got.size(), exp_q.size());
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) check("out_beat", got[i], exp_q[i]);
    got.delete();
  endtask

  initial begin
    logic acc;
    int idx;
    int guard;
    reset = 1'b1; clear = 1'b0;
    i_tvalid = 1'b0; i_tdata = '0; i_tlast = 1'b0; o_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_tvalid", o_tvalid, 0);
    check("rst_tlast", o_tlast, 0);
    check("rst_tdata", o_tdata, 0);
    check("rst_symcnt", sym_count, 0);
    check("rst_trunc", trunc_err, 0);
    check("rst_iready", i_tready, 1);

    // 1: two complete symbols
    trunc_seen = 0;
    run_frame(20, 0, 1'b0);
    compare_out(20, 0);
    check("t1_symcnt", sym_count, 2);
    check("t1_trunc", trunc_seen, 0);

    // 2: frame ends mid-symbol
    trunc_seen = 0;
    run_frame(15, 0, 1'b0);
    compare_out(15, 0);
    check("t2_symcnt", sym_count, 1);
    check("t2_trunc", trunc_seen, 1);

    // 3: random backpressure
    trunc_seen = 0;
    run_frame(20, 0, 1'b1);
    compare_out(20, 0);
    check("t3_symcnt", sym_count, 2);
    check("t3_trunc", trunc_seen, 0);

    // 4: trailing guard sample, then a fresh frame
    trunc_seen = 0;
    run_frame(21, 0, 1'b0);
    compare_out(21, 0);
    check("t4a_symcnt", sym_count, 2);
    run_frame(20, 200, 1'b0);
    compare_out(20, 200);
    check("t4b_symcnt", sym_count, 2);
    check("t4_trunc", trunc_seen, 0);

    // empty frame: a lone tlast beat
    trunc_seen = 0;
    run_frame(1, 0, 1'b0);
    compare_out(1, 0);
    check("empty_trunc", trunc_seen, 1);
    check("empty_symcnt", sym_count, 0);

    // 5: clear after output sample 5 of the first symbol
    idx = 0;
    guard = 0;
    while ((got.size() == 0 || got[got.size() - 1][31:0] != 32'd5) && guard < 100) begin
      cycle(1'b1, 32'(idx), 1'b0, 1'b1, acc);
      if (acc) idx++;
      guard++;
    end
    if (guard >= 100) check("t5_timeout", guard, 0);
    @(negedge clk);
    clear = 1'b1; i_tvalid = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("t5_tvalid", o_tvalid, 0);
    check("t5_symcnt", sym_count, 0);
    check("t5_state", dut.state, 0);
    got.delete();
    trunc_seen = 0;
    run_frame(10, 0, 1'b0);
    compare_out(10, 0);
    check("t5_trunc", trunc_seen, 0);

    // 6: async reset between edges with a stalled output beat
    idx = 0;
    guard = 0;
    while (idx < 3 && guard < 100) begin
      cycle(1'b1, 32'(50 + idx), 1'b0, 1'b0, acc);
      if (acc) idx++;
      guard++;
    end
    @(negedge clk);
    #1;
    check("t6_pre_tvalid", o_tvalid, 1);
    check("t6_pre_tdata", o_tdata, 52);
    #1;
    reset = 1'b1;
    #1;
    check("t6_tvalid", o_tvalid, 0);
    check("t6_symcnt", sym_count, 0);
    check("t6_state", dut.state, 0);
    #1;
    reset = 1'b0;
    i_tvalid = 1'b0;
    got.delete();
    trunc_seen = 0;
    run_frame(10, 100, 1'b0);
    compare_out(10, 100);
    check("t6_symcnt_after", sym_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
